// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
// Contents: fetch_state_e (RUN/DROP), NOP_INSTR, PC_INCR, PC_PLUS8.
package fetch_pkg;

  // RUN: normal fetching. DROP: an outstanding response belongs to a
  // squashed path and must be discarded when it arrives.
  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } fetch_state_e;

  // MOV r0, r0 - used as the bubble instruction in IF/ID.
  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  localparam int PC_INCR  = 4;
  localparam int PC_PLUS8 = 8;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - single-entry holding slot for an accepted fetch response
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   wr_i                 capture wr_instr_i/wr_pc_i, entry becomes full
//   rd_i                 entry consumed, becomes empty
//   clr_i                discard entry (flush/redirect)
//   wr_instr_i, wr_pc_i  instruction word and its PC tag
//   full_o               entry holds valid data
//   instr_o, pc_o        stored instruction and PC tag
module fetch_skid_buffer #(
  parameter int BITS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_i,
  input  logic            rd_i,
  input  logic            clr_i,
  input  logic [BITS-1:0] wr_instr_i,
  input  logic [BITS-1:0] wr_pc_i,
  output logic            full_o,
  output logic [BITS-1:0] instr_o,
  output logic [BITS-1:0] pc_o
);

  logic            full_q;
  logic [BITS-1:0] instr_q;
  logic [BITS-1:0] pc_q;

  // Clear beats write (a flushed cycle drops its response); write beats
  // read so a same-cycle refill keeps the entry occupied.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      full_q <= 1'b0;
    end else if (wr_i) begin
      full_q <= 1'b1;
    end else if (rd_i) begin
      full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (wr_i && !clr_i) begin
      instr_q <= wr_instr_i;
      pc_q    <= wr_pc_i;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - ARM pipeline instruction-fetch stage with IF/ID register
// Optional feature macro: FETCH_PERF_EN (FetchCount/StallCount counters).
// Ports:
//   CLK, RESET                    clock, synchronous active-high reset
//   StallF, StallD, FlushD        hazard unit controls
//   BranchTakenE, ALUResultE      execute redirect and target (higher priority)
//   PCSrcW, ResultW               writeback PC write and target
//   IMemReq, IMemAddr             fetch request and word-aligned address
//   IMemAck, IMemRdata            fetch response
//   PCF                           current fetch PC
//   InstrD, PCPlus8D, ValidD      IF/ID register towards decode
//   FetchCount, StallCount        performance counters (0 without FETCH_PERF_EN)
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          BITS     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            BranchTakenE,
  input  logic [BITS-1:0] ALUResultE,
  input  logic            PCSrcW,
  input  logic [BITS-1:0] ResultW,
  output logic            IMemReq,
  output logic [BITS-1:0] IMemAddr,
  input  logic            IMemAck,
  input  logic [BITS-1:0] IMemRdata,
  output logic [BITS-1:0] PCF,
  output logic [BITS-1:0] InstrD,
  output logic [BITS-1:0] PCPlus8D,
  output logic            ValidD,
  output logic [31:0]     FetchCount,
  output logic [31:0]     StallCount
);

  fetch_state_e    state_q, state_d;
  logic [BITS-1:0] pc_q, pc_d;
  logic            pending_q, pending_d;
  logic [BITS-1:0] req_addr_q, req_addr_d;
  logic [BITS-1:0] instr_q, instr_d;
  logic [BITS-1:0] pcplus8_q, pcplus8_d;
  logic            valid_q, valid_d;

  logic            redirect;
  logic [BITS-1:0] target;
  logic            imem_req;
  logic [BITS-1:0] cur_addr;
  logic            ack;
  logic            accept;
  logic            direct;
  logic            buf_wr, buf_rd, buf_clr, buf_full;
  logic [BITS-1:0] buf_instr, buf_pc;
  logic            load_valid;

  assign redirect = BranchTakenE | PCSrcW;
  assign target   = BranchTakenE ? ALUResultE : ResultW;

  // A pending request is always re-presented, even in DROP, so the address
  // stays stable until the memory acknowledges it.
  assign imem_req = !RESET && (pending_q || (state_q == RUN && !buf_full && !StallF));
  assign cur_addr = pending_q ? req_addr_q : pc_q;
  assign IMemReq  = imem_req;
  assign IMemAddr = {cur_addr[BITS-1:2], 2'b00};

  // Acks without a live request (e.g. a response to a request cut by reset)
  // are ignored.
  assign ack    = IMemAck && imem_req;
  assign accept = (state_q == RUN) && ack && !redirect;

  assign direct  = accept && !StallD && !buf_full;
  assign buf_clr = FlushD || redirect;
  assign buf_wr  = accept && !direct;
  assign buf_rd  = !buf_clr && !StallD && buf_full;

  assign load_valid = !buf_clr && !StallD && (buf_full || accept);

  fetch_skid_buffer #(.BITS(BITS)) u_skid (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .wr_i       (buf_wr),
    .rd_i       (buf_rd),
    .clr_i      (buf_clr),
    .wr_instr_i (IMemRdata),
    .wr_pc_i    (cur_addr),
    .full_o     (buf_full),
    .instr_o    (buf_instr),
    .pc_o       (buf_pc)
  );

  // Request tracking and PC / state next-state logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    req_addr_d = req_addr_q;

    if (ack) begin
      pending_d = 1'b0;
    end else if (imem_req && !pending_q) begin
      pending_d  = 1'b1;
      req_addr_d = pc_q;
    end

    case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d = target;
          // The request still in flight is on the wrong path.
          if (imem_req && !ack) state_d = DROP;
        end else if (ack) begin
          pc_d = pc_q + BITS'(PC_INCR);
        end
      end
      DROP: begin
        if (redirect) pc_d = target;
        if (ack) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // IF/ID register next-state.
  always_comb begin
    instr_d   = instr_q;
    pcplus8_d = pcplus8_q;
    valid_d   = valid_q;

    if (buf_clr) begin
      instr_d = BITS'(NOP_INSTR);
      valid_d = 1'b0;
    end else if (StallD) begin
      valid_d = valid_q;
    end else if (load_valid) begin
      // Buffered word is older than anything arriving this cycle.
      instr_d   = buf_full ? buf_instr : IMemRdata;
      pcplus8_d = (buf_full ? buf_pc : cur_addr) + BITS'(PC_PLUS8);
      valid_d   = 1'b1;
    end else begin
      instr_d = BITS'(NOP_INSTR);
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= RUN;
      pc_q       <= BITS'(RESET_PC);
      pending_q  <= 1'b0;
      req_addr_q <= '0;
      instr_q    <= BITS'(NOP_INSTR);
      pcplus8_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      pcplus8_q  <= pcplus8_d;
      valid_q    <= valid_d;
    end
  end

  assign PCF      = pc_q;
  assign InstrD   = instr_q;
  assign PCPlus8D = pcplus8_q;
  assign ValidD   = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load_valid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (StallF || StallD) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign StallCount = stall_cnt_q;
`else
  assign FetchCount = 32'd0;
  assign StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized checks of fetch_stage against a queue-based model
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'hE1A0_0000;

  logic        CLK = 1'b0;
  logic        RESET, StallF, StallD, FlushD, BranchTakenE, PCSrcW, IMemAck;
  logic [31:0] ALUResultE, ResultW, IMemRdata;
  logic        IMemReq, ValidD;
  logic [31:0] IMemAddr, PCF, InstrD, PCPlus8D, FetchCount, StallCount;

  fetch_stage #(.BITS(32), .RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RESET(RESET), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW),
    .ResultW(ResultW), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck),
    .IMemRdata(IMemRdata), .PCF(PCF), .InstrD(InstrD), .PCPlus8D(PCPlus8D),
    .ValidD(ValidD), .FetchCount(FetchCount), .StallCount(StallCount)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  // Reference model: fetch PC, the one outstanding memory request, the list
  // of fetched-but-undelivered instructions, and what decode sees.
  logic [31:0] m_pc;
  logic        m_out;
  logic [31:0] m_out_addr;
  logic        m_stale;
  item_t       m_held[$];
  logic [31:0] m_instr, m_p8;
  logic        m_valid;
  logic [31:0] m_fc, m_sc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_req(output logic r, output logic [31:0] a);
    r = !RESET && (m_out || (m_held.size() == 0 && !StallF));
    a = m_out ? m_out_addr : m_pc;
    a[1:0] = 2'b00;
  endtask

  task automatic deliver(input item_t it);
    m_instr = it.instr;
    m_p8    = it.pc + 32'd8;
    m_valid = 1'b1;
    m_fc++;
  endtask

  task automatic model_step(input logic r, input logic [31:0] a);
    logic        ack, redir, got;
    logic [31:0] tgt;
    item_t       it;
    if (RESET) begin
      m_pc = RST_PC; m_out = 1'b0; m_stale = 1'b0; m_held.delete();
      m_instr = NOP; m_valid = 1'b0; m_p8 = 32'd0; m_fc = 0; m_sc = 0;
      return;
    end
    ack   = IMemAck && r;
    redir = BranchTakenE || PCSrcW;
    tgt   = BranchTakenE ? ALUResultE : ResultW;
    got   = ack && !m_stale && !redir;
    it.instr = mem_word(a);
    it.pc    = a;
    if (StallF || StallD) m_sc++;
    if (redir) m_pc = tgt;
    else if (got) m_pc = m_pc + 32'd4;
    if (ack) begin
      m_out = 1'b0; m_stale = 1'b0;
    end else if (r) begin
      m_out = 1'b1; m_out_addr = a;
      if (redir) m_stale = 1'b1;
    end
    if (FlushD || redir) begin
      m_valid = 1'b0; m_instr = NOP; m_held.delete();
    end else if (StallD) begin
      if (got) m_held.push_back(it);
    end else if (m_held.size() > 0) begin
      deliver(m_held.pop_front());
      if (got) m_held.push_back(it);
    end else if (got) begin
      deliver(it);
    end else begin
      m_valid = 1'b0; m_instr = NOP;
    end
  endtask

  // One clock: check combinational outputs, respond, step model, check registers.
  task automatic cycle();
    logic        r;
    logic [31:0] a;
    #1;
    model_req(r, a);
    check("IMemReq", {31'd0, IMemReq}, {31'd0, r});
    if (r) check("IMemAddr", IMemAddr, a);
    check("PCF_pre", PCF, m_pc);
    IMemRdata = IMemAck ? mem_word(a) : $urandom;
    model_step(r, a);
    @(posedge CLK);
    #1;
    check("ValidD", {31'd0, ValidD}, {31'd0, m_valid});
    if (m_valid) begin
      check("InstrD", InstrD, m_instr);
      check("PCPlus8D", PCPlus8D, m_p8);
    end
    check("PCF", PCF, m_pc);
`ifdef FETCH_PERF_EN
    check("FetchCount", FetchCount, m_fc);
    check("StallCount", StallCount, m_sc);
`else
    check("FetchCount", FetchCount, 32'd0);
    check("StallCount", StallCount, 32'd0);
`endif
  endtask

  task automatic idle_inputs();
    RESET = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    BranchTakenE = 1'b0; PCSrcW = 1'b0; IMemAck = 1'b0;
    ALUResultE = 32'd0; ResultW = 32'd0;
  endtask

  initial begin
    logic [31:0] t;
    idle_inputs();
    IMemRdata = 32'd0;
    m_pc = 0; m_out = 0; m_out_addr = 0; m_stale = 0;
    m_instr = NOP; m_p8 = 0; m_valid = 0; m_fc = 0; m_sc = 0;

    // Reset
    RESET = 1'b1;
    cycle();
    cycle();
    check("rst_PCF", PCF, RST_PC);
    check("rst_ValidD", {31'd0, ValidD}, 32'd0);
    check("rst_InstrD", InstrD, NOP);
    check("rst_PCPlus8D", PCPlus8D, 32'd0);
    check("rst_FetchCount", FetchCount, 32'd0);
    check("rst_StallCount", StallCount, 32'd0);

    // Same-cycle acks, no stalls: sequential stream
    idle_inputs();
    IMemAck = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("seq_PCF", PCF, 32'(4 * (i + 1)));
      check("seq_ValidD", {31'd0, ValidD}, 32'd1);
      check("seq_PCPlus8D", PCPlus8D, 32'(4 * i + 8));
      check("seq_InstrD", InstrD, mem_word(32'(4 * i)));
    end
    // Three fetch-stall cycles
    IMemAck = 1'b0; StallF = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
`ifdef FETCH_PERF_EN
    check("perf_fetch", FetchCount, 32'd10);
    check("perf_stall", StallCount, 32'd3);
`else
    check("perf_fetch_off", FetchCount, 32'd0);
    check("perf_stall_off", StallCount, 32'd0);
`endif

    // Delayed ack with a branch while the request is outstanding
    idle_inputs();
    cycle();
    BranchTakenE = 1'b1; ALUResultE = 32'h100;
    cycle();
    idle_inputs();
    cycle();
    #1;
    check("drop_addr_hold", IMemAddr, 32'h28);
    IMemAck = 1'b1;
    cycle();
    check("drop_ValidD", {31'd0, ValidD}, 32'd0);
    #1;
    check("drop_new_addr", IMemAddr, 32'h100);
    cycle();
    check("br_ValidD", {31'd0, ValidD}, 32'd1);
    check("br_PCPlus8D", PCPlus8D, 32'h108);

    // Ack during decode stall: response parks in the skid buffer
    StallD = 1'b1;
    cycle();
    IMemAck = 1'b0;
    #1;
    check("skid_no_req", {31'd0, IMemReq}, 32'd0);
    cycle();
    StallD = 1'b0;
    cycle();
    check("skid_InstrD", InstrD, mem_word(32'h104));
    check("skid_PCPlus8D", PCPlus8D, 32'h10C);
    IMemAck = 1'b1;
    cycle();
    check("skid_resume", PCF, 32'h10C);

    // Execute redirect beats writeback redirect
    IMemAck = 1'b0;
    BranchTakenE = 1'b1; ALUResultE = 32'h40;
    PCSrcW = 1'b1; ResultW = 32'h80;
    cycle();
    check("prio_PCF", PCF, 32'h40);
    idle_inputs();
    IMemAck = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Flush with stall and a full buffer
    StallD = 1'b1;
    cycle();
    IMemAck = 1'b0; FlushD = 1'b1;
    cycle();
    check("flush_ValidD", {31'd0, ValidD}, 32'd0);
    check("flush_InstrD", InstrD, NOP);
    idle_inputs();
    #1;
    check("flush_buf_empty", {31'd0, IMemReq}, 32'd1);
    cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RESET  = ($urandom_range(199) == 0);
      StallF = ($urandom_range(4) == 0);
      StallD = ($urandom_range(4) == 0);
      FlushD = ($urandom_range(15) == 0);
      BranchTakenE = ($urandom_range(11) == 0);
      PCSrcW = ($urandom_range(15) == 0);
      t = $urandom; t[1:0] = 2'b00; ALUResultE = t;
      t = $urandom; t[1:0] = 2'b00; ResultW = t;
      IMemAck = ($urandom_range(1) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
